// File: rtl/mandelbrot_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mandelbrot_scheduler                                                        |
// | Raster-scans a frame across two engine lanes and returns results in order.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module mandelbrot_scheduler #(
   parameter int H_RES       = 640,
   parameter int V_RES       = 480,
   parameter int COORD_WIDTH = 11
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic signed [COORD_WIDTH-1:0] center_x,
   input  logic signed [COORD_WIDTH-1:0] center_y,
   input  logic [7:0]                    zoom_level,
   input  logic [5:0]                    max_iter_limit,
   output logic signed [COORD_WIDTH-1:0] cfg_center_x,
   output logic signed [COORD_WIDTH-1:0] cfg_center_y,
   output logic [7:0]                    cfg_zoom_level,
   output logic [5:0]                    cfg_max_iter,
   output logic                          eng_enable,
   output logic [9:0]                    e0_pixel_x,
   output logic [9:0]                    e0_pixel_y,
   output logic [9:0]                    e1_pixel_x,
   output logic [9:0]                    e1_pixel_y,
   output logic                          e0_pixel_valid,
   output logic                          e1_pixel_valid,
   input  logic [5:0]                    e0_iter,
   input  logic [5:0]                    e1_iter,
   input  logic                          e0_result_valid,
   input  logic                          e1_result_valid,
   input  logic                          e0_busy,
   input  logic                          e1_busy,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [9:0]                    out_x,
   output logic [9:0]                    out_y,
   output logic [5:0]                    out_iter,
   output logic                          frame_busy,
   output logic                          frame_done
);

   localparam logic [9:0] c_x_last = 10'(H_RES - 1);
   localparam logic [9:0] c_y_last = 10'(V_RES - 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_ABORT = 2'd3} state_t;
   typedef enum logic [1:0] {LN_FREE = 2'd0, LN_ISSUED = 2'd1, LN_RELEASE = 2'd2} lane_t;

   state_t     r_state, w_state_nxt;
   lane_t      r_lane [2];
   lane_t      w_lane_nxt [2];
   logic [9:0] r_lane_x [2];
   logic [9:0] r_lane_y [2];
   logic [9:0] r_scan_x, r_scan_y;
   logic       r_disp_ptr, r_out_ptr, r_frame_done;

   logic [1:0] w_busy, w_res_valid;
   logic       w_start_ok, w_active, w_abort, w_disp_req, w_dispatch, w_disp_lane;
   logic       w_last_disp, w_out_valid, w_xfer, w_last_xfer;
   logic [9:0] w_disp_x, w_disp_y, w_scan_x_nxt, w_scan_y_nxt;
   logic [5:0] w_iter_sel;

   assign w_busy      = {e1_busy, e0_busy};
   assign w_res_valid = {e1_result_valid, e0_result_valid};
   assign w_start_ok  = (r_state == ST_IDLE) && start;
   assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign w_abort     = w_active && abort;

   // The accepted start dispatches pixel (0,0) itself so lane 0 is live on the next cycle
   assign w_disp_lane = w_start_ok ? 1'b0 : r_disp_ptr;
   assign w_disp_x    = w_start_ok ? 10'd0 : r_scan_x;
   assign w_disp_y    = w_start_ok ? 10'd0 : r_scan_y;
   assign w_disp_req  = w_start_ok || ((r_state == ST_RUN) && !abort);
   assign w_dispatch  = w_disp_req && (r_lane[w_disp_lane] == LN_FREE) && !w_busy[w_disp_lane];
   assign w_last_disp = (w_disp_x == c_x_last) && (w_disp_y == c_y_last);

   assign w_scan_x_nxt = (w_disp_x == c_x_last) ? 10'd0 : w_disp_x + 10'd1;
   assign w_scan_y_nxt = (w_disp_x != c_x_last) ? w_disp_y :
                         (w_disp_y == c_y_last) ? 10'd0 : w_disp_y + 10'd1;

   assign w_out_valid = w_active && (r_lane[r_out_ptr] == LN_ISSUED) && w_res_valid[r_out_ptr];
   assign w_xfer      = w_out_valid && out_ready && !abort;
   assign w_last_xfer = w_xfer && (r_state == ST_DRAIN) &&
                        (r_lane_x[r_out_ptr] == c_x_last) && (r_lane_y[r_out_ptr] == c_y_last);
   assign w_iter_sel  = r_out_ptr ? e1_iter : e0_iter;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = (w_dispatch && w_last_disp) ? ST_DRAIN : ST_RUN;
         ST_RUN: begin
            if (abort)                           w_state_nxt = ST_ABORT;
            else if (w_dispatch && w_last_disp)  w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (abort)            w_state_nxt = ST_ABORT;
            else if (w_last_xfer) w_state_nxt = ST_IDLE;
         end
         ST_ABORT: if ((r_lane[0] == LN_FREE) && (r_lane[1] == LN_FREE)) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_lane_nxt[i] = r_lane[i];
         case (r_lane[i])
            LN_FREE:    if (w_dispatch && (w_disp_lane == 1'(i))) w_lane_nxt[i] = LN_ISSUED;
            LN_ISSUED:  if (w_abort || (r_state == ST_ABORT) || (w_xfer && (r_out_ptr == 1'(i))))
                           w_lane_nxt[i] = LN_RELEASE;
            LN_RELEASE: if (!w_busy[i]) w_lane_nxt[i] = LN_FREE;
            default:    w_lane_nxt[i] = LN_FREE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_lane[0]      <= LN_FREE;
         r_lane[1]      <= LN_FREE;
         r_lane_x[0]    <= '0;
         r_lane_x[1]    <= '0;
         r_lane_y[0]    <= '0;
         r_lane_y[1]    <= '0;
         r_scan_x       <= '0;
         r_scan_y       <= '0;
         r_disp_ptr     <= 1'b0;
         r_out_ptr      <= 1'b0;
         r_frame_done   <= 1'b0;
         cfg_center_x   <= '0;
         cfg_center_y   <= '0;
         cfg_zoom_level <= '0;
         cfg_max_iter   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_lane[0]    <= w_lane_nxt[0];
         r_lane[1]    <= w_lane_nxt[1];
         r_frame_done <= w_last_xfer;
         if (w_dispatch) begin
            r_lane_x[w_disp_lane] <= w_disp_x;
            r_lane_y[w_disp_lane] <= w_disp_y;
            r_scan_x              <= w_scan_x_nxt;
            r_scan_y              <= w_scan_y_nxt;
            r_disp_ptr            <= ~w_disp_lane;
         end else if (w_start_ok) begin
            r_scan_x   <= '0;
            r_scan_y   <= '0;
            r_disp_ptr <= 1'b0;
         end
         if (w_start_ok) begin
            r_out_ptr      <= 1'b0;
            cfg_center_x   <= center_x;
            cfg_center_y   <= center_y;
            cfg_zoom_level <= zoom_level;
            cfg_max_iter   <= max_iter_limit;
         end else if (w_xfer) begin
            r_out_ptr <= ~r_out_ptr;
         end
      end
   end

   assign eng_enable     = (r_state != ST_IDLE);
   assign frame_busy     = (r_state != ST_IDLE);
   assign frame_done     = r_frame_done;
   assign e0_pixel_valid = (r_lane[0] == LN_ISSUED);
   assign e1_pixel_valid = (r_lane[1] == LN_ISSUED);
   assign e0_pixel_x     = r_lane_x[0];
   assign e0_pixel_y     = r_lane_y[0];
   assign e1_pixel_x     = r_lane_x[1];
   assign e1_pixel_y     = r_lane_y[1];
   assign out_valid      = w_out_valid;
   assign out_x          = w_out_valid ? r_lane_x[r_out_ptr] : 10'd0;
   assign out_y          = w_out_valid ? r_lane_y[r_out_ptr] : 10'd0;
   assign out_iter       = w_out_valid ? w_iter_sel : 6'd0;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mandelbrot_scheduler                                                     |
// | Scoreboard bench with behavioural engines of programmable latency.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mandelbrot_scheduler;
   localparam int H = 4;
   localparam int V = 2;
   localparam int CW = 11;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
   logic signed [CW-1:0] center_x = '0, center_y = '0;
   logic [7:0] zoom_level = '0;
   logic [5:0] max_iter_limit = '0;
   logic signed [CW-1:0] cfg_center_x, cfg_center_y;
   logic [7:0] cfg_zoom_level;
   logic [5:0] cfg_max_iter, e0_iter, e1_iter, out_iter;
   logic eng_enable, e0_pixel_valid, e1_pixel_valid, e0_result_valid, e1_result_valid;
   logic e0_busy, e1_busy, out_valid, frame_busy, frame_done;
   logic [9:0] e0_pixel_x, e0_pixel_y, e1_pixel_x, e1_pixel_y, out_x, out_y;

   always #5 clk = ~clk;

   mandelbrot_scheduler #(.H_RES(H), .V_RES(V), .COORD_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .center_x(center_x), .center_y(center_y), .zoom_level(zoom_level),
      .max_iter_limit(max_iter_limit),
      .cfg_center_x(cfg_center_x), .cfg_center_y(cfg_center_y),
      .cfg_zoom_level(cfg_zoom_level), .cfg_max_iter(cfg_max_iter),
      .eng_enable(eng_enable),
      .e0_pixel_x(e0_pixel_x), .e0_pixel_y(e0_pixel_y),
      .e1_pixel_x(e1_pixel_x), .e1_pixel_y(e1_pixel_y),
      .e0_pixel_valid(e0_pixel_valid), .e1_pixel_valid(e1_pixel_valid),
      .e0_iter(e0_iter), .e1_iter(e1_iter),
      .e0_result_valid(e0_result_valid), .e1_result_valid(e1_result_valid),
      .e0_busy(e0_busy), .e1_busy(e1_busy),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_iter(out_iter),
      .frame_busy(frame_busy), .frame_done(frame_done)
   );

   function automatic logic [5:0] iter_of(input int x, input int y, input int m);
      if (m == 0) return 6'd0;
      return 6'((x * 3 + y * 5) % (m + 1));
   endfunction

   // Engine model: IDLE(0) -> COMPUTE(1) for lat cycles -> DONE(2) until pixel_valid drops
   logic [1:0] pv;
   logic [1:0] est [2];
   int         ecnt [2];
   int         lat [2];
   logic [9:0] ex [2];
   logic [9:0] ey [2];
   assign pv = {e1_pixel_valid, e0_pixel_valid};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            est[i] <= 2'd0; ecnt[i] <= 0; ex[i] <= '0; ey[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            case (est[i])
               2'd0: if (pv[i]) begin
                  est[i]  <= 2'd1;
                  ecnt[i] <= lat[i] - 1;
                  ex[i]   <= (i == 0) ? e0_pixel_x : e1_pixel_x;
                  ey[i]   <= (i == 0) ? e0_pixel_y : e1_pixel_y;
               end
               2'd1: if (ecnt[i] == 0) est[i] <= pv[i] ? 2'd2 : 2'd0;
                     else ecnt[i] <= ecnt[i] - 1;
               default: if (!pv[i]) est[i] <= 2'd0;
            endcase
         end
      end
   end

   assign e0_busy         = (est[0] != 2'd0);
   assign e1_busy         = (est[1] != 2'd0);
   assign e0_result_valid = (est[0] == 2'd2);
   assign e1_result_valid = (est[1] == 2'd2);
   assign e0_iter = (est[0] == 2'd2) ? iter_of(int'(ex[0]), int'(ey[0]), int'(cfg_max_iter)) : 6'd0;
   assign e1_iter = (est[1] == 2'd2) ? iter_of(int'(ex[1]), int'(ey[1]), int'(cfg_max_iter)) : 6'd0;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [5:0] it;
   } pix_t;
   pix_t sb[$];

   int n_chk = 0, n_pass = 0;
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_xfer = 0, n_done = 0, last_xfer_cyc = -10;
   always @(negedge clk) begin
      pix_t e;
      if (rst_n && out_valid && out_ready && !abort) begin
         n_xfer++;
         last_xfer_cyc = cyc;
         if (sb.size() == 0) check_val("xfer_unexpected", 1, 0);
         else begin
            e = sb.pop_front();
            check_val("out_x", 32'(out_x), 32'(e.x));
            check_val("out_y", 32'(out_y), 32'(e.y));
            check_val("out_iter", 32'(out_iter), 32'(e.it));
         end
      end
      if (frame_done) begin
         n_done++;
         check_val("done_timing", cyc, last_xfer_cyc + 1);
         check_val("done_busy", 32'(frame_busy), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input int m);
      pix_t p;
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) begin
            p.x = 10'(x); p.y = 10'(y); p.it = iter_of(x, y, m);
            sb.push_back(p);
         end
   endtask

   task automatic start_frame(input int cx, input int mi, input int l0, input int l1);
      lat[0] = l0; lat[1] = l1;
      center_x = CW'(cx); max_iter_limit = 6'(mi);
      start = 1'b1;
      push_frame(mi);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (frame_busy && k < budget) begin
         tick();
         k++;
      end
      check_val(tag, 32'(frame_busy), 0);
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d0, xb, chg, lchg;
      logic [9:0] ox, oy, l0x, l1x;
      logic [5:0] oit;
      lat[0] = 1; lat[1] = 1;

      // Reset state
      #12;
      check_val("rst_busy", 32'(frame_busy), 0);
      check_val("rst_enable", 32'(eng_enable), 0);
      check_val("rst_pv0", 32'(e0_pixel_valid), 0);
      check_val("rst_out_valid", 32'(out_valid), 0);
      check_val("rst_done", 32'(frame_done), 0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Small frame with start timing
      d0 = n_done;
      start_frame(0, 0, 1, 1);
      check_val("c1_busy", 32'(frame_busy), 1);
      check_val("c1_pv0", 32'(e0_pixel_valid), 1);
      check_val("c1_x0", 32'(e0_pixel_x), 0);
      check_val("c1_y0", 32'(e0_pixel_y), 0);
      check_val("c1_pv1", 32'(e1_pixel_valid), 0);
      tick();
      check_val("c2_pv1", 32'(e1_pixel_valid), 1);
      check_val("c2_x1", 32'(e1_pixel_x), 1);
      tick();
      check_val("c3_out_valid", 32'(out_valid), 1);
      wait_idle("t1_timeout", 200);
      check_val("t1_done_cnt", n_done, d0 + 1);
      check_val("t1_sb_empty", sb.size(), 0);

      // Reorder plus config isolation
      d0 = n_done;
      center_y = 11'sd37; zoom_level = 8'd9;
      start_frame(-128, 20, 10, 2);
      repeat (5) tick();
      center_x = 11'sd300; center_y = -11'sd5; zoom_level = 8'd200; max_iter_limit = 6'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_val("cfg_cx", 32'(cfg_center_x), -128);
      check_val("cfg_cy", 32'(cfg_center_y), 37);
      check_val("cfg_zoom", 32'(cfg_zoom_level), 9);
      check_val("cfg_iter", 32'(cfg_max_iter), 20);
      wait_idle("t2_timeout", 500);
      check_val("t2_done_cnt", n_done, d0 + 1);
      check_val("t2_sb_empty", sb.size(), 0);
      tick();
      check_val("t2_no_restart", 32'(frame_busy), 0);

      // Backpressure
      xb = n_xfer;
      start_frame(0, 3, 1, 1);
      for (int k = 0; k < 50 && (n_xfer - xb) < 3; k++) tick();
      out_ready = 1'b0;
      repeat (8) tick();
      ox = out_x; oy = out_y; oit = out_iter; l0x = e0_pixel_x; l1x = e1_pixel_x;
      check_val("bp_valid", 32'(out_valid), 1);
      chg = 0; lchg = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (!out_valid || out_x !== ox || out_y !== oy || out_iter !== oit) chg++;
         if (!e0_pixel_valid || !e1_pixel_valid || e0_pixel_x !== l0x || e1_pixel_x !== l1x) lchg++;
      end
      check_val("bp_out_hold", chg, 0);
      check_val("bp_lane_hold", lchg, 0);
      check_val("bp_xfer_cnt", n_xfer - xb, 3);
      out_ready = 1'b1;
      wait_idle("t3_timeout", 200);
      check_val("t3_sb_empty", sb.size(), 0);

      // Abort while pixel 3 is presented
      d0 = n_done;
      xb = n_xfer;
      start_frame(0, 0, 1, 1);
      for (int k = 0; k < 50; k++) begin
         if (out_valid && out_x == 10'd3 && out_y == 10'd0) break;
         tick();
      end
      check_val("ab_seen_p3", 32'(out_valid && out_x == 10'd3), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("ab_pv0", 32'(e0_pixel_valid), 0);
      check_val("ab_pv1", 32'(e1_pixel_valid), 0);
      check_val("ab_out_valid", 32'(out_valid), 0);
      check_val("ab_xfer_cnt", n_xfer - xb, 3);
      wait_idle("ab_timeout", 100);
      check_val("ab_no_done", n_done, d0);
      sb.delete();
      start_frame(0, 0, 1, 1);
      check_val("ab_restart_pv", 32'(e0_pixel_valid), 1);
      check_val("ab_restart_xy", 32'({e0_pixel_x, e0_pixel_y}), 0);
      wait_idle("ab2_timeout", 200);
      check_val("ab2_done_cnt", n_done, d0 + 1);

      // Asynchronous reset mid-frame
      start_frame(0, 7, 1, 1);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check_val("ar_busy", 32'(frame_busy), 0);
      check_val("ar_enable", 32'(eng_enable), 0);
      check_val("ar_pv", 32'({e0_pixel_valid, e1_pixel_valid}), 0);
      check_val("ar_out_valid", 32'(out_valid), 0);
      check_val("ar_lane_xy", 32'({e0_pixel_x, e1_pixel_x}), 0);
      check_val("ar_cfg_iter", 32'(cfg_max_iter), 0);
      sb.delete();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
      d0 = n_done;
      start_frame(0, 7, 1, 1);
      check_val("ar_restart_pv", 32'(e0_pixel_valid), 1);
      check_val("ar_restart_xy", 32'({e0_pixel_x, e0_pixel_y}), 0);
      wait_idle("ar_timeout", 200);
      check_val("ar_done_cnt", n_done, d0 + 1);
      check_val("ar_sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mandelbrot_scheduler.md
# mandelbrot_scheduler

- Frame-level controller for two `mandelbrot_engine` instances.
- Latches view parameters at frame start and raster-scans every pixel of an `H_RES`×`V_RES` frame.
- Dispatches pixels alternately to engine lanes 0 and 1.
- Returns results in strict raster order on a valid/ready stream to the framebuffer writer.

## Interface

Parameters:
- `H_RES`, 640, pixels per line.
- `V_RES`, 480, lines per frame.
- `COORD_WIDTH`, 11, width of center coordinates.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin frame; sampled only in IDLE.
- `abort`  in  1  cancel current frame; sampled in RUN/DRAIN.
- `center_x`, `center_y`  in  `COORD_WIDTH` signed  view center, sampled at accepted `start`.
- `zoom_level`  in  8  sampled at accepted `start`.
- `max_iter_limit`  in  6  sampled at accepted `start`.
- `cfg_center_x`, `cfg_center_y`, `cfg_zoom_level`, `cfg_max_iter`  out  as inputs  latched config to both engines.
- `eng_enable`  out  1  engine enable, shared by both engines.
- `e0_pixel_x`, `e0_pixel_y`, `e1_pixel_x`, `e1_pixel_y`  out  10  lane coordinates.
- `e0_pixel_valid`, `e1_pixel_valid`  out  1  lane request.
- `e0_iter`, `e1_iter`  in  6  engine `iteration_count`.
- `e0_result_valid`, `e1_result_valid`, `e0_busy`, `e1_busy`  in  1  engine status.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts.
- `out_x`, `out_y`  out  10  pixel coordinate of result.
- `out_iter`  out  6  iteration count.
- `frame_busy`  out  1  high outside IDLE.
- `frame_done`  out  1  one-cycle pulse after last result transfers.

## Operation

Top states:
- IDLE → RUN on `start`. Latch the four config values; clear the scan counter, `disp_ptr` and `out_ptr` (all to lane 0).
- RUN → DRAIN when pixel (`H_RES`-1, `V_RES`-1) is dispatched.
- DRAIN → IDLE when that pixel's result transfers. Pulse `frame_done` on that transfer.
- RUN/DRAIN → ABORT on `abort`. Abort has priority over a dispatch or transfer in the same cycle; neither takes effect.
- ABORT → IDLE when both lanes are FREE. No `frame_done`.

Per-lane states (FREE, ISSUED, RELEASE):
- **FREE → ISSUED** (dispatch):
  - Conditions: state RUN, lane == `disp_ptr`, lane FREE, engine `busy`=0.
  - Load lane x/y from the scan counter and raise `eX_pixel_valid`.
  - Advance the scan: x increments; at x=`H_RES`-1, x wraps to 0 and y increments.
  - Toggle `disp_ptr`.
  - At most one dispatch per cycle.
- **ISSUED**: `pixel_valid`, x and y are held stable.
- **ISSUED → RELEASE** (transfer of `out_ptr` lane): drop `pixel_valid` and toggle `out_ptr`. In ABORT, every ISSUED lane moves to RELEASE immediately.
- **RELEASE → FREE** when engine `busy`=0.

Output stream:
- `out_valid` = lane[`out_ptr`] is ISSUED && `eX_result_valid`[`out_ptr`], and state is RUN or DRAIN.
- `out_x`, `out_y`, `out_iter` are taken from the `out_ptr` lane.
- Transfer occurs when `out_valid` && `out_ready`.
- Results from the lane that is not `out_ptr` wait in the engine's DONE state; no buffering is needed.

Other rules:
- `eng_enable` = state ≠ IDLE.
- `start` is ignored while `frame_busy`. Input config changes mid-frame have no effect.
- Async reset mid-frame returns to IDLE immediately with every output at its reset value. The engines are reset by the same `rst_n`.

## Timing

Reset values:
- All outputs 0: `cfg_*`, lane coordinates, `pixel_valid`, `out_*`, `eng_enable`, `frame_busy`, `frame_done`.
- All lanes FREE; both pointers 0.

Frame start sequence:
- `start` sampled high in cycle 0.
- Cycle 1: `frame_busy`=1 and `e0_pixel_valid`=1 with (0,0).
- Cycle 2: `e1_pixel_valid`=1 with (1,0).

Latencies:
- With real engines and `max_iter`=0, lane 0 `result_valid` rises at cycle 3. With `out_ready`=1, `out_valid`=1 at cycle 3.
- A lane is re-dispatchable no earlier than 2 cycles after its transfer: one cycle in RELEASE, then the engine reports `busy`=0.

Output behaviour:
- `out_valid`, `out_x`, `out_y`, `out_iter` remain stable while `out_valid` && !`out_ready`.
- The output path is combinational from lane registers and engine status. There is no additional latency.

## Test plan

- **Small-frame throughput:** `H_RES`=4, `V_RES`=2, real engines, `max_iter`=0, `out_ready`=1 → 8 transfers in order (0,0),(1,0)…(3,1), all `out_iter`=0; exactly one `frame_done`, on the cycle after the (3,1) transfer; `frame_busy` falls with it.
- **Reorder:** stub engines; lane 1 returns after 2 cycles, lane 0 after 10 → (1,0) is not emitted before (0,0); order is preserved across the frame.
- **Backpressure:** `out_ready`=0 for 20 cycles mid-frame → `out_valid` and its data are held constant; no more than 2 pixels outstanding; no lane is re-dispatched.
- **Config isolation:** `start` with `center_x`=-128 and `max_iter`=20, then change the inputs mid-frame and pulse `start` → `cfg_*` unchanged; frame count unaffected.
- **Abort:** `abort` at pixel 3 with `out_valid`=1 → no transfer that cycle; both `pixel_valid` drop next cycle; IDLE after engines report `busy`=0; no `frame_done`; the next `start` begins at (0,0).
- **Reset:** `rst_n` low for 1 cycle mid-frame → all outputs 0 asynchronously; a new frame starts cleanly.
